// File: rtl/global_buf_loader_if.sv
// Valid/ready stream of 128-bit global-buffer lines from the host side into the loader.
// The host drives the master modport and the loader takes the slave modport.
interface global_buf_loader_if #(
    parameter int unsigned DATA_WIDTH = 128
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );
endinterface

// File: rtl/global_buf_loader.sv
// Streams the input-feature region, then the weight region, into the global buffer SRAM,
// then hands the SRAM port back and kicks the systolic controller.
module global_buf_loader #(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned CNT_WIDTH  = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic [ADDR_WIDTH-1:0] INIT_INPUT_ADDR,
    input  logic [ADDR_WIDTH-1:0] INIT_WEIGHT_ADDR,
    input  logic [CNT_WIDTH-1:0]  N_INPUT_LINES,
    input  logic [CNT_WIDTH-1:0]  N_WEIGHT_LINES,
    global_buf_loader_if.slave    s,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  write,
    output logic                  load_data,
    output logic                  compute_start,
    input  logic                  compute_done,
    output logic                  busy
);

    typedef enum logic [2:0] {
        StIdle,
        StLoadIn,
        StLoadWt,
        StFlush,
        StGap,
        StStart,
        StWaitDone
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] in_base_q, wt_base_q;
    logic [CNT_WIDTH-1:0]  n_in_q, n_wt_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic                  s_ready_c;
    logic                  accept;
    logic                  cfg_accept;
    logic                  last_in, last_wt, last_beat;
    logic [ADDR_WIDTH-1:0] region_base;

    assign s.s_ready  = s_ready_c;
    assign accept     = s_ready_c & s.s_valid;
    assign cfg_accept = (state_q == StIdle) & cfg_start;

    // The counter restarts at 0 for each region, so one counter serves both.
    assign last_in     = (cnt_q == n_in_q - CNT_WIDTH'(1));
    assign last_wt     = (cnt_q == n_wt_q - CNT_WIDTH'(1));
    assign last_beat   = (state_q == StLoadIn) ? last_in : last_wt;
    assign region_base = (state_q == StLoadIn) ? in_base_q : wt_base_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cfg_start) begin
                    if (N_INPUT_LINES != '0) begin
                        state_d = StLoadIn;
                    end else if (N_WEIGHT_LINES != '0) begin
                        state_d = StLoadWt;
                    end else begin
                        state_d = StGap;
                    end
                end
            end
            StLoadIn: begin
                if (accept && last_in) begin
                    state_d = (n_wt_q != '0) ? StLoadWt : StFlush;
                end
            end
            StLoadWt: begin
                if (accept && last_wt) begin
                    state_d = StFlush;
                end
            end
            StFlush:    state_d = StGap;
            StGap:      state_d = StStart;
            StStart:    state_d = StWaitDone;
            StWaitDone: begin
                if (compute_done) begin
                    state_d = StIdle;
                end
            end
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        s_ready_c     = 1'b0;
        load_data     = 1'b0;
        compute_start = 1'b0;
        busy          = (state_q != StIdle);
        unique case (state_q)
            StLoadIn, StLoadWt: begin
                s_ready_c = 1'b1;
                load_data = 1'b1;
            end
            // Last registered write drains here while the loader still owns the port.
            StFlush: load_data = 1'b1;
            StStart: compute_start = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_base_q <= '0;
            wt_base_q <= '0;
            n_in_q    <= '0;
            n_wt_q    <= '0;
            cnt_q     <= '0;
            waddr     <= '0;
            wdata     <= '0;
            write     <= 1'b0;
        end else begin
            write <= accept;
            if (cfg_accept) begin
                in_base_q <= INIT_INPUT_ADDR;
                wt_base_q <= INIT_WEIGHT_ADDR;
                n_in_q    <= N_INPUT_LINES;
                n_wt_q    <= N_WEIGHT_LINES;
                cnt_q     <= '0;
            end
            if (accept) begin
                wdata <= s.s_data;
                waddr <= region_base + ADDR_WIDTH'(cnt_q);
                cnt_q <= last_beat ? '0 : cnt_q + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_global_buf_loader.sv
// Scoreboard bench for global_buf_loader: the driver queues expected SRAM writes and start
// times, and a monitor forked alongside it checks every cycle.
module tb_global_buf_loader;
    localparam int unsigned AW = 13;
    localparam int unsigned DW = 128;
    localparam int unsigned CW = 13;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_start = 1'b0;
    logic [AW-1:0] init_in = '0;
    logic [AW-1:0] init_wt = '0;
    logic [CW-1:0] n_in = '0;
    logic [CW-1:0] n_wt = '0;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          write, load_data, compute_start, busy;
    logic          compute_done = 1'b0;

    int            vectors = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [AW+DW-1:0] exp_q[$];
    int            start_q[$];
    bit            acc_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    global_buf_loader_if #(.DATA_WIDTH(DW)) sif ();

    global_buf_loader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_start       (cfg_start),
        .INIT_INPUT_ADDR (init_in),
        .INIT_WEIGHT_ADDR(init_wt),
        .N_INPUT_LINES   (n_in),
        .N_WEIGHT_LINES  (n_wt),
        .s               (sif),
        .waddr           (waddr),
        .wdata           (wdata),
        .write           (write),
        .load_data       (load_data),
        .compute_start   (compute_start),
        .compute_done    (compute_done),
        .busy            (busy)
    );

    task automatic chk(input string name, input logic [159:0] got, input logic [159:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, got, want);
        end
    endtask

    function automatic logic [127:0] mk(input int tag, input int i);
        logic [31:0] w;
        w = {8'(tag), 8'(i >> 8), 8'(i), 8'(i * 37 + tag)};
        return {w, ~w, w ^ 32'h5A5A_A5A5, w[15:0], w[31:16]};
    endfunction

    task automatic mon_step();
        logic [AW+DW-1:0] e;
        int want_cyc;
        if (rst) begin
            acc_prev = 1'b0;
            return;
        end
        chk("write_vs_accept", write, acc_prev);
        if (write) begin
            chk("load_data_on_write", load_data, 1'b1);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {waddr, wdata}, '0);
                if ({waddr, wdata} == '0) chk("unexpected_write_flag", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("write_line", {waddr, wdata}, e);
            end
        end
        if (compute_start) begin
            if (start_q.size() == 0) begin
                chk("unexpected_compute_start", compute_start, 1'b0);
            end else begin
                want_cyc = start_q.pop_front();
                if (want_cyc >= 0) chk("start_cycle", cyc, want_cyc);
            end
        end
        acc_prev = sif.s_valid & sif.s_ready;
    endtask

    // Called at posedge+1; config inputs are scrambled afterwards to prove they were latched.
    task automatic pulse_cfg(input logic [AW-1:0] ib, input logic [AW-1:0] wb, input int ni,
                             input int nw, output int c0);
        init_in   = ib;
        init_wt   = wb;
        n_in      = CW'(ni);
        n_wt      = CW'(nw);
        cfg_start = 1'b1;
        c0        = cyc;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        init_in   = ~ib;
        init_wt   = ~wb;
        n_in      = CW'(ni + 7);
        n_wt      = CW'(nw + 3);
    endtask

    task automatic drive_beat(input logic [127:0] d, input bit bp);
        bit acc = 1'b0;
        if (bp) begin
            for (int k = 0; k < 4 && $urandom_range(0, 1) == 0; k++) begin
                sif.s_valid = 1'b0;
                sif.s_data  = {4{$urandom}};
                @(posedge clk);
                #1;
            end
        end
        sif.s_valid = 1'b1;
        sif.s_data  = d;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = sif.s_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("beat_accept_timeout", acc, 1'b1);
    endtask

    task automatic run_load(input logic [AW-1:0] ib, input logic [AW-1:0] wb, input int ni,
                            input int nw, input int tag, input bit bp, input int poke,
                            input int done_wait);
        int c0;
        int n;
        bit seen = 1'b0;
        logic [AW-1:0] a;
        logic [127:0] d;
        n = ni + nw;
        pulse_cfg(ib, wb, ni, nw, c0);
        start_q.push_back(bp ? -1 : (n == 0 ? c0 + 2 : c0 + n + 3));
        for (int i = 0; i < n; i++) begin
            a = (i < ni) ? ib + AW'(i) : wb + AW'(i - ni);
            d = mk(tag, i);
            exp_q.push_back({a, d});
            if (i == poke) begin
                cfg_start = 1'b1;
                init_in   = 13'h0555;
                n_in      = 13'd1;
                n_wt      = 13'd1;
            end
            drive_beat(d, bp);
            cfg_start = 1'b0;
        end
        sif.s_valid = 1'b0;
        if (!bp && n > 0) begin
            @(negedge clk);
            chk("flush_load_data", load_data, 1'b1);
            chk("flush_s_ready", sif.s_ready, 1'b0);
            @(negedge clk);
            chk("gap_load_data", load_data, 1'b0);
            chk("gap_write", write, 1'b0);
        end else if (n == 0) begin
            @(negedge clk);
            chk("gap_load_data_zero", load_data, 1'b0);
            chk("gap_busy_zero", busy, 1'b1);
        end
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            seen = compute_start;
        end
        chk("compute_start_seen", seen, 1'b1);
        chk("busy_at_start", busy, 1'b1);
        @(posedge clk);
        #1;
        if (poke >= 0) begin
            cfg_start = 1'b1;
            @(posedge clk);
            #1;
            cfg_start = 1'b0;
        end
        repeat (done_wait) begin
            @(posedge clk);
            #1;
        end
        chk("wait_done_busy", busy, 1'b1);
        chk("wait_done_load_data", load_data, 1'b0);
        chk("wait_done_s_ready", sif.s_ready, 1'b0);
        compute_done = 1'b1;
        @(posedge clk);
        #1;
        compute_done = 1'b0;
        chk("idle_busy", busy, 1'b0);
        chk("all_writes_seen", exp_q.size(), 0);
    endtask

    task automatic reset_mid_load();
        int c0;
        pulse_cfg(13'h0040, 13'h0800, 256, 128, c0);
        for (int i = 0; i < 100; i++) begin
            // The 100th write is killed by reset before the monitor samples it.
            if (i < 99) exp_q.push_back({13'h0040 + AW'(i), mk(7, i)});
            sif.s_valid = 1'b1;
            sif.s_data  = mk(7, i);
            @(posedge clk);
            #1;
        end
        #1;
        rst = 1'b1;
        #1;
        chk("rst_write", write, 1'b0);
        chk("rst_load_data", load_data, 1'b0);
        chk("rst_s_ready", sif.s_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_compute_start", compute_start, 1'b0);
        chk("rst_waddr", waddr, '0);
        chk("rst_wdata", wdata, '0);
        chk("rst_pending_writes", exp_q.size(), 0);
        sif.s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", sif.s_ready, 1'b0);
        chk("post_rst_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        run_load(13'h0040, 13'h0800, 4, 2, 8, 1'b0, -1, 1);
    endtask

    task automatic main_seq();
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        #12;
        chk("reset_write", write, 1'b0);
        chk("reset_load_data", load_data, 1'b0);
        chk("reset_s_ready", sif.s_ready, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_compute_start", compute_start, 1'b0);
        chk("reset_waddr", waddr, '0);
        chk("reset_wdata", wdata, '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_load(13'h0000, 13'h1000, 256, 128, 1, 1'b0, -1, 3);
        run_load(13'h0300, 13'h0600, 16, 8, 2, 1'b1, -1, 0);
        run_load(13'h0100, 13'h0200, 0, 4, 3, 1'b0, -1, 0);
        run_load(13'h0100, 13'h0200, 0, 0, 4, 1'b0, -1, 2);
        run_load(13'h0010, 13'h1FFE, 2, 4, 5, 1'b0, -1, 0);
        run_load(13'h0020, 13'h0A00, 8, 8, 6, 1'b0, 11, 4);
        run_load(13'h0030, 13'h0B00, 3, 3, 9, 1'b0, -1, 0);
        reset_mid_load();
        repeat (3) @(posedge clk);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
            main_seq();
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
